pc_sequencer: RTL and testbench

- Program-counter controller for the core. Owns ProgCtr and sequences instruction fetch from start to halt.
- Drives the branch-target lookup table index. Applies the returned target as an absolute or PC-relative jump.
- Tracks run/done status and exposes cycle and retired-instruction counters for program benchmarking.
- Sits between the decoder (Halt/Branch/Stall/index) and instruction memory (ProgCtr).

---
 rtl/pc_seq_pkg.sv | 35 +++
 rtl/pc_sequencer_sat_counter.sv | 25 ++
 rtl/pc_sequencer.sv | 101 ++++++++++
 tb/tb_pc_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types, default widths and next-address rule for the PC sequencer.
// Latency: n/a (declarations and a pure combinational function).
// Backpressure: n/a.
package pc_seq_pkg;

    localparam int DEF_D  = 12;
    localparam int DEF_A  = 6;
    localparam int DEF_CW = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Address of the next instruction when the current one is not stalled or a halt.
    // Relative targets are two's-complement offsets, so a plain D-bit add wraps correctly.
    function automatic logic [DEF_D-1:0] next_pc(
        input logic [DEF_D-1:0] pc,
        input logic [DEF_D-1:0] target,
        input logic             abs,
        input logic             br
    );
        logic [DEF_D-1:0] res;
        if (br && abs) begin
            res = target;
        end else if (br) begin
            res = pc + target;
        end else begin
            res = pc + 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/pc_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear, used for run-time benchmarking.
// Latency: count updates on the edge after inc/clr are sampled.
// Backpressure: none; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CW = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] count
);

    // Clear wins over increment; increment stops once every bit is set.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {CW{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter controller: sequences fetch from Start to Halt, applies LUT branch targets.
// Latency: LutAddr is combinational; ProgCtr/state/counters update on the next Clk edge.
// Backpressure: Stall freezes ProgCtr and InstrCnt while CycleCnt keeps counting.
import pc_seq_pkg::*;

module pc_sequencer #(
    parameter int D  = DEF_D,
    parameter int A  = DEF_A,
    parameter int CW = DEF_CW
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Halt,
    input  logic          Stall,
    input  logic          BranchEn,
    input  logic          AbsJump,
    input  logic [A-1:0]  LutIdx,
    output logic [A-1:0]  LutAddr,
    input  logic [D-1:0]  LutTarget,
    output logic [D-1:0]  ProgCtr,
    output logic          Running,
    output logic          Done,
    output logic [CW-1:0] CycleCnt,
    output logic [CW-1:0] InstrCnt
);

    state_t         state;
    state_t         state_nxt;
    logic [D-1:0]   pc_nxt;
    logic           cnt_clr;
    logic           cyc_inc;
    logic           ins_inc;

    // The branch LUT is looked up in the same cycle the decoder presents the index.
    assign LutAddr = LutIdx;

    // Next-state, next-PC and counter controls; Stall outranks Halt, Halt outranks branch.
    always_comb begin
        state_nxt = state;
        pc_nxt    = ProgCtr;
        cnt_clr   = 1'b0;
        cyc_inc   = 1'b0;
        ins_inc   = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (Start) begin
                    state_nxt = ST_RUN;
                    pc_nxt    = '0;
                    cnt_clr   = 1'b1;
                end
            end
            ST_RUN: begin
                cyc_inc = 1'b1;
                if (!Stall) begin
                    ins_inc = 1'b1;
                    if (Halt) begin
                        state_nxt = ST_DONE;
                    end else begin
                        pc_nxt = next_pc(ProgCtr, LutTarget, AbsJump, BranchEn);
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                pc_nxt    = '0;
            end
        endcase
    end

    // State and fetch address registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= ST_IDLE;
            ProgCtr <= '0;
        end else begin
            state   <= state_nxt;
            ProgCtr <= pc_nxt;
        end
    end

    assign Running = (state == ST_RUN);
    assign Done    = (state == ST_DONE);

    sat_counter #(.CW(CW)) u_cycle_cnt (
        .Clk   (Clk),
        .Reset (Reset),
        .clr   (cnt_clr),
        .inc   (cyc_inc),
        .count (CycleCnt)
    );

    sat_counter #(.CW(CW)) u_instr_cnt (
        .Clk   (Clk),
        .Reset (Reset),
        .clr   (cnt_clr),
        .inc   (ins_inc),
        .count (InstrCnt)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, hand sequences, random vs model.
// Latency: checks each cycle on the falling edge after the sampling rising edge.
// Backpressure: exercises Stall priority and counter saturation.
module tb_pc_sequencer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start, Halt, Stall, BranchEn, AbsJump;
    logic [5:0]  LutIdx;
    logic [5:0]  LutAddr;
    logic [11:0] LutTarget;
    logic [11:0] ProgCtr;
    logic        Running, Done;
    logic [15:0] CycleCnt, InstrCnt;

    logic [11:0] lut [64];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int m_mode;  // 0 idle, 1 run, 2 done
    int m_pc, m_ic, m_cc;

    typedef struct {
        logic       st, sl, h, b, a;
        logic [5:0] idx;
        int         pc, run, done, ic, cc;
    } vec_t;

    vec_t vecs[$];

    always #5 Clk = ~Clk;

    // Behaves as the branch-target LUT memory.
    always_comb LutTarget = lut[LutAddr];

    pc_sequencer dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .Halt      (Halt),
        .Stall     (Stall),
        .BranchEn  (BranchEn),
        .AbsJump   (AbsJump),
        .LutIdx    (LutIdx),
        .LutAddr   (LutAddr),
        .LutTarget (LutTarget),
        .ProgCtr   (ProgCtr),
        .Running   (Running),
        .Done      (Done),
        .CycleCnt  (CycleCnt),
        .InstrCnt  (InstrCnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int pc, input int run, input int done,
                           input int ic, input int cc);
        chk({tag, " pc"},   {20'd0, ProgCtr},  pc);
        chk({tag, " run"},  {31'd0, Running},  run);
        chk({tag, " done"}, {31'd0, Done},     done);
        chk({tag, " icnt"}, {16'd0, InstrCnt}, ic);
        chk({tag, " ccnt"}, {16'd0, CycleCnt}, cc);
    endtask

    task automatic drive(input logic st, input logic sl, input logic h, input logic b,
                         input logic a, input logic [5:0] idx);
        Start = st; Stall = sl; Halt = h; BranchEn = b; AbsJump = a; LutIdx = idx;
    endtask

    task automatic step(input logic st, input logic sl, input logic h, input logic b,
                        input logic a, input logic [5:0] idx);
        drive(st, sl, h, b, a, idx);
        @(posedge Clk);
        @(negedge Clk);
    endtask

    function automatic vec_t v(input logic st, input logic sl, input logic h, input logic b,
                               input logic a, input int idx, input int pc, input int run,
                               input int done, input int ic, input int cc);
        vec_t r;
        r.st = st; r.sl = sl; r.h = h; r.b = b; r.a = a; r.idx = idx[5:0];
        r.pc = pc; r.run = run; r.done = done; r.ic = ic; r.cc = cc;
        return r;
    endfunction

    // Model of one clock edge, written from the sequencing rules.
    task automatic model_edge(input logic st, input logic sl, input logic h, input logic b,
                              input logic a, input logic [5:0] idx);
        int t;
        t = int'(lut[idx]);
        if (m_mode != 1) begin
            if (st) begin
                m_mode = 1; m_pc = 0; m_ic = 0; m_cc = 0;
            end
        end else begin
            if (m_cc < 65535) m_cc++;
            if (!sl) begin
                if (m_ic < 65535) m_ic++;
                if (h)           m_mode = 2;
                else if (b && a) m_pc = t;
                else if (b)      m_pc = (m_pc + t) % 4096;
                else             m_pc = (m_pc + 1) % 4096;
            end
        end
    endtask

    initial begin
        Reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 64; i++) lut[i] = 12'h000;
        lut[0] = 12'hFFB;  // -5
        lut[1] = 12'd20;
        lut[2] = 12'hFFF;  // -1
        lut[3] = 12'h198;
        lut[4] = 12'h010;
        lut[5] = 12'h003;
        lut[6] = 12'h000;
        lut[7] = 12'h025;

        repeat (2) @(negedge Clk);
        chk_all("reset", 0, 0, 0, 0, 0);
        Reset = 1'b0;
        @(negedge Clk);
        chk_all("idle", 0, 0, 0, 0, 0);

        // Reset mid-RUN must clear everything without a clock edge.
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 7);
        chk_all("pre-reset", 12'h025, 1, 0, 1, 1);
        #2 Reset = 1'b1;
        #1 chk_all("async reset", 0, 0, 0, 0, 0);
        @(negedge Clk);
        Reset = 1'b0;
        step(1, 0, 0, 0, 0, 0);
        chk_all("restart", 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk_all("restart+1", 1, 1, 0, 1, 1);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;

        // Directed vector table: {st,sl,h,b,a,idx} -> {pc,run,done,icnt,ccnt}
        vecs.push_back(v(1,0,0,0,0,0, 12'h000,1,0, 0, 0));
        vecs.push_back(v(0,0,0,0,0,0, 12'h001,1,0, 1, 1));
        vecs.push_back(v(0,0,0,0,0,0, 12'h002,1,0, 2, 2));
        vecs.push_back(v(0,0,0,0,0,0, 12'h003,1,0, 3, 3));
        vecs.push_back(v(0,0,0,0,0,0, 12'h004,1,0, 4, 4));
        vecs.push_back(v(0,0,1,0,0,0, 12'h004,0,1, 5, 5));
        vecs.push_back(v(0,0,0,0,0,0, 12'h004,0,1, 5, 5));
        vecs.push_back(v(1,0,0,0,0,0, 12'h000,1,0, 0, 0));
        vecs.push_back(v(0,0,0,1,1,4, 12'h010,1,0, 1, 1));
        vecs.push_back(v(0,0,0,1,0,1, 12'h024,1,0, 2, 2));
        vecs.push_back(v(0,0,0,1,1,4, 12'h010,1,0, 3, 3));
        vecs.push_back(v(0,0,0,1,0,0, 12'h00B,1,0, 4, 4));
        vecs.push_back(v(0,0,0,1,1,4, 12'h010,1,0, 5, 5));
        vecs.push_back(v(0,0,0,1,0,2, 12'h00F,1,0, 6, 6));
        vecs.push_back(v(0,0,0,1,1,5, 12'h003,1,0, 7, 7));
        vecs.push_back(v(0,0,0,1,0,0, 12'hFFE,1,0, 8, 8));
        vecs.push_back(v(0,0,0,1,1,5, 12'h003,1,0, 9, 9));
        vecs.push_back(v(0,0,0,0,0,0, 12'h004,1,0,10,10));
        vecs.push_back(v(0,0,0,0,0,0, 12'h005,1,0,11,11));
        vecs.push_back(v(0,0,0,0,1,3, 12'h006,1,0,12,12));
        vecs.push_back(v(0,0,0,1,1,5, 12'h003,1,0,13,13));
        vecs.push_back(v(0,0,0,0,0,0, 12'h004,1,0,14,14));
        vecs.push_back(v(0,0,0,0,0,0, 12'h005,1,0,15,15));
        vecs.push_back(v(0,0,0,1,1,3, 12'h198,1,0,16,16));
        vecs.push_back(v(0,0,0,1,0,6, 12'h198,1,0,17,17));
        vecs.push_back(v(1,0,0,0,0,0, 12'h199,1,0,18,18));
        vecs.push_back(v(0,1,1,1,1,3, 12'h199,1,0,18,19));
        vecs.push_back(v(0,1,1,1,1,3, 12'h199,1,0,18,20));
        vecs.push_back(v(0,1,1,1,1,3, 12'h199,1,0,18,21));
        vecs.push_back(v(0,0,1,1,1,3, 12'h199,0,1,19,22));
        vecs.push_back(v(0,0,0,0,0,0, 12'h199,0,1,19,22));

        foreach (vecs[i]) begin
            step(vecs[i].st, vecs[i].sl, vecs[i].h, vecs[i].b, vecs[i].a, vecs[i].idx);
            chk_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].run, vecs[i].done,
                    vecs[i].ic, vecs[i].cc);
        end

        // PC wrap and counter saturation over a long run.
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4095; i++) step(0, 0, 0, 0, 0, 0);
        chk_all("pc at fff", 12'hFFF, 1, 0, 4095, 4095);
        step(0, 0, 0, 0, 0, 0);
        chk_all("pc wrap", 12'h000, 1, 0, 4096, 4096);
        drive(0, 1, 0, 0, 0, 0);
        repeat (61439) @(posedge Clk);
        @(negedge Clk);
        chk_all("ccnt sat", 12'h000, 1, 0, 4096, 16'hFFFF);
        repeat (5) @(posedge Clk);
        @(negedge Clk);
        chk_all("ccnt hold", 12'h000, 1, 0, 4096, 16'hFFFF);

        // Random stimulus against the reference model.
        Reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge Clk);
        Reset = 1'b0;
        for (int i = 0; i < 64; i++) lut[i] = 12'($urandom);
        m_mode = 0; m_pc = 0; m_ic = 0; m_cc = 0;
        for (int i = 0; i < 3000; i++) begin
            logic st, sl, h, b, a;
            logic [5:0] idx;
            st  = ($urandom_range(0, 9) == 0);
            sl  = ($urandom_range(0, 3) == 0);
            h   = ($urandom_range(0, 29) == 0);
            b   = ($urandom_range(0, 2) == 0);
            a   = 1'($urandom);
            idx = 6'($urandom);
            drive(st, sl, h, b, a, idx);
            #1 chk("rnd lutaddr", {26'd0, LutAddr}, {26'd0, idx});
            model_edge(st, sl, h, b, a, idx);
            @(posedge Clk);
            @(negedge Clk);
            chk_all("rnd", m_pc, (m_mode == 1) ? 1 : 0, (m_mode == 2) ? 1 : 0, m_ic, m_cc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
